// File: rtl/ram_bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, programmable divisor and TX-done interrupt.
// Optional parity bit is enabled by defining UART_PARITY_EN.
module ram_bus_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [15:0] r_div;
  logic [2:0]  r_ctrl;
  logic        r_overflow;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_txd;
  logic        r_irq;

  logic [AW:0] w_level;
  logic [31:0] w_level32;
  logic [3:0]  w_level_sat;
  logic        w_full;
  logic        w_empty;
  logic        w_busy;
  logic        w_wr;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_bit_end;
  logic [7:0]  w_head;
  logic        w_unused;

  assign w_level     = r_wptr - r_rptr;
  assign w_level32   = 32'(w_level);
  assign w_level_sat = (w_level32 > 32'd15) ? 4'hF : w_level32[3:0];
  assign w_full      = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (w_level == '0);
  assign w_busy      = (r_state != S_IDLE);
  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign w_bit_end   = (r_cnt == 16'd0);

  assign w_wr       = ce & we;
  assign w_push_req = w_wr & (addr[3:2] == 2'd0) & sel[0];
  // The FSM pulls the next byte either from IDLE or right at the end of a stop bit.
  assign w_pop      = r_ctrl[0] & ~w_empty &
                      ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
  assign w_push     = w_push_req & (~w_full | w_pop);

  assign txd = r_txd;
  assign irq = r_irq;

  assign w_unused = &{1'b0, addr[31:4], addr[1:0], sel[3:2], data_i[31:16]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= data_i[7:0];
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div      <= DIV_RESET;
      r_ctrl     <= 3'b001;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr && addr[3:2] == 2'd2) begin
        if (sel[0]) r_div[7:0]  <= data_i[7:0];
        if (sel[1]) r_div[15:8] <= data_i[15:8];
      end
      if (w_wr && addr[3:2] == 2'd3 && sel[0]) begin
        r_ctrl[1:0] <= data_i[1:0];
`ifdef UART_PARITY_EN
        r_ctrl[2]   <= data_i[2];
`endif
      end
      // A rejected push wins over a simultaneous W1C so no loss goes unreported.
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end else if (w_wr && addr[3:2] == 2'd1 && sel[0] && data_i[3]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= r_ctrl[1] & w_empty & ~w_busy;
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= ^w_head;
            r_cnt   <= r_div;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= r_div;
            r_bit   <= 3'd0;
            r_txd   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= r_div;
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_txd   <= r_par ^ r_ctrl[2];
              r_state <= S_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_txd   <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= r_div;
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_par   <= ^w_head;
              r_cnt   <= r_div;
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    data_o = 32'd0;
    if (ce && !we) begin
      case (addr[3:2])
        2'd1:    data_o = {24'd0, w_level_sat, r_overflow, w_busy, w_empty, w_full};
        2'd2:    data_o = {16'd0, r_div};
        2'd3:    data_o = {29'd0, r_ctrl};
        default: data_o = 32'd0;
      endcase
    end
  end

endmodule
